pixel_scan_sequencer: RTL
=========================

# pixel_scan_sequencer

Frame-level driver and result collector for the ray-tracing pipeline. On `start` it walks the raster in row-major order, presenting one `pixel_x`/`pixel_y` pair per non-stalled cycle to the tracer. It tracks each issued pixel through a delay line matched to the tracer's latency. When that pixel's `hit`/distance result returns, it writes the result to the framebuffer write port. It is the source of the tracer's pixel inputs and the sink of its `hit_out`/`test_data` outputs.

## Interface
- `H_RES`, default 800: pixels per line.
- `V_RES`, default 600: lines per frame.
- `PIPE_LATENCY`, default 40: cycles from a pixel coordinate change at the tracer input to its result being valid on `hit_in`/`dist_in`; minimum 1.
- `ADDR_W`, default 19: framebuffer address width; must satisfy 2^ADDR_W ≥ H_RES·V_RES.

Ports:
- `sysclk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: single-cycle frame request; honoured only in IDLE.
- `stall` in 1: freezes issue, delay line and drain counter for the cycle.
- `pixel_x` out 10: current column, 0..H_RES-1.
- `pixel_y` out 10: current row, 0..V_RES-1.
- `issue_valid` out 1: `pixel_x`/`pixel_y` carry a pixel being issued this cycle.
- `hit_in` in 1: tracer hit flag.
- `dist_in` in 16: tracer closest-hit distance, bits [15:0].
- `fb_we` out 1: framebuffer write strobe.
- `fb_addr` out ADDR_W: linear address, y·H_RES+x.
- `fb_data` out 17: `{hit_in, dist_in}` captured for that pixel.
- `busy` out 1: high in all states except IDLE.
- `frame_done` out 1: one-cycle pulse when the last write has completed.

## Operation
States are IDLE, ISSUE, DRAIN and DONE.

- **IDLE:** `start`=1 moves to ISSUE. The x, y and address counters are cleared to 0.
- **ISSUE:** `issue_valid`=1 while `stall`=0.
  - Each non-stalled cycle pushes `{valid=1, addr}` into the delay line, then advances the counters.
  - x increments. When x reaches H_RES-1 it wraps to 0 and y increments. The address increments by 1; there is no multiplier.
  - After issuing (H_RES-1, V_RES-1), go to DRAIN. `pixel_x`/`pixel_y` hold the last pixel.
- **DRAIN:** a counter runs PIPE_LATENCY non-stalled cycles, and the delay line pushes `valid=0` each of those cycles. When the counter completes, go to DONE.
- **DONE:** `frame_done`=1 for one cycle, then return to IDLE.

Delay line:
- Depth is PIPE_LATENCY. It shifts only when `stall`=0.
- If the tail entry is valid in a non-stalled cycle T, `hit_in`/`dist_in` are sampled in T. In T+1 the block registers `fb_we`=1, `fb_addr`=tail addr and `fb_data`={hit_in, dist_in}.
- During `stall`, `fb_we`=0 and nothing is sampled.

`start` outside IDLE is ignored; there is no queueing.

`stall` in any state freezes the state, counters and delay line. `frame_done` is not emitted while stalled: DONE holds, and the pulse occurs in the first non-stalled DONE cycle.

Reset (asserted at any time, including mid-frame):
- All outputs go to 0 and the state goes to IDLE.
- All delay-line valid bits clear, so no stale writes after reset.
- A new `start` begins from pixel (0,0).

## Timing
- `start` sampled in cycle 0 makes pixel (0,0) valid on the outputs in cycle 1.
- With no stall, a frame issues H_RES·V_RES pixels in consecutive cycles.
- Pixel issued in non-stalled cycle t: its `fb_we` is high PIPE_LATENCY+1 non-stalled cycles after t.
- `frame_done` follows the final `fb_we` by exactly 1 cycle, with no stall.
- No-stall frame length from `start` to `frame_done` is H_RES·V_RES + PIPE_LATENCY + 2 cycles.
- `busy` rises the cycle after `start` and falls the cycle after `frame_done`.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
1. **Full small frame.** H_RES=4, V_RES=3, PIPE_LATENCY=5; `start` pulse; tracer model returns hit=x[0], dist=16·y+x.
   - 12 `fb_we` pulses, addresses 0..11 in order.
   - `fb_data` = {x[0], 16y+x}.
   - `frame_done` 19 cycles after `start`.
2. **Line wrap.** Same parameters: after (3,0) the next issue is (0,1), address 4; after (3,2) the state enters DRAIN with `issue_valid`=0.
3. **Stall mid-frame.** `stall` high for 3 cycles during issue of (2,1).
   - Outputs and `fb_*` are frozen.
   - No duplicate or missing address.
   - `frame_done` is delayed by exactly 3 cycles.
4. **Stall in DRAIN/DONE.** Stall is held on the DONE cycle; `frame_done` waits for de-assertion and pulses once.
5. **Start while busy.** `start` pulses at cycles 3 and 10 of a frame; exactly one frame (12 writes), then IDLE.
6. **Reset mid-frame.** `rst_n` low at pixel 6.
   - All outputs are 0 immediately.
   - No `fb_we` after release.
   - A new `start` writes addresses 0..11 correctly.

Source files
------------

// File: rtl/pixel_scan_sequencer_if.sv
// Tracer and framebuffer signal bundle around the pixel scan sequencer.
// The master side belongs to the sequencer and the slave side to its environment.
interface pixel_scan_sequencer_if #(
  parameter int ADDR_W = 19
);
  logic              start;
  logic              stall;
  logic [9:0]        pixel_x;
  logic [9:0]        pixel_y;
  logic              issue_valid;
  logic              hit_in;
  logic [15:0]       dist_in;
  logic              fb_we;
  logic [ADDR_W-1:0] fb_addr;
  logic [16:0]       fb_data;
  logic              busy;
  logic              frame_done;

  modport master (
    input  start, stall, hit_in, dist_in,
    output pixel_x, pixel_y, issue_valid, fb_we, fb_addr, fb_data, busy, frame_done
  );

  modport slave (
    output start, stall, hit_in, dist_in,
    input  pixel_x, pixel_y, issue_valid, fb_we, fb_addr, fb_data, busy, frame_done
  );
endinterface

// File: rtl/pixel_scan_sequencer.sv
// Raster walker for the ray tracer: issues pixels in row-major order, tracks them through a
// latency-matched delay line and writes each returning result to the framebuffer.
module pixel_scan_sequencer #(
  parameter int H_RES        = 800,
  parameter int V_RES        = 600,
  parameter int PIPE_LATENCY = 40,
  parameter int ADDR_W       = 19
) (
  input  logic                  sysclk,
  input  logic                  rst_n,
  pixel_scan_sequencer_if.master bus
);
  localparam int CNT_W = $clog2(PIPE_LATENCY + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state_r;
  state_t              state_s;
  logic [9:0]          x_r;
  logic [9:0]          y_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [CNT_W-1:0]    drain_cnt_r;
  logic [PIPE_LATENCY-1:0] dl_valid_r;
  logic [ADDR_W-1:0]   dl_addr_r [PIPE_LATENCY];
  logic                issue_valid_r;
  logic                fb_we_r;
  logic [ADDR_W-1:0]   fb_addr_r;
  logic [16:0]         fb_data_r;
  logic                busy_r;
  logic                frame_done_r;
  logic                x_wrap_s;
  logic                last_pix_s;
  logic                drain_end_s;
  logic                tail_take_s;

  assign x_wrap_s    = (x_r == 10'(H_RES - 1));
  assign last_pix_s  = x_wrap_s && (y_r == 10'(V_RES - 1));
  assign drain_end_s = (drain_cnt_r == CNT_W'(PIPE_LATENCY - 1));
  assign tail_take_s = !bus.stall && dl_valid_r[PIPE_LATENCY-1];

  // State register.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; a stalled cycle holds the current state.
  always_comb begin
    state_s = state_r;
    if (bus.stall) begin
      state_s = state_r;
    end else begin
      case (state_r)
        IDLE:    if (bus.start) state_s = ISSUE; else state_s = IDLE;
        ISSUE:   if (last_pix_s) state_s = DRAIN; else state_s = ISSUE;
        DRAIN:   if (drain_end_s) state_s = DONE; else state_s = DRAIN;
        DONE:    state_s = IDLE;
        default: state_s = IDLE;
      endcase
    end
  end

  // Raster counters and drain counter; the address tracks the raster incrementally.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      x_r         <= 10'd0;
      y_r         <= 10'd0;
      addr_r      <= {ADDR_W{1'b0}};
      drain_cnt_r <= {CNT_W{1'b0}};
    end else if (!bus.stall) begin
      case (state_r)
        IDLE: begin
          x_r         <= 10'd0;
          y_r         <= 10'd0;
          addr_r      <= {ADDR_W{1'b0}};
          drain_cnt_r <= {CNT_W{1'b0}};
        end
        ISSUE: begin
          if (!last_pix_s) begin
            addr_r <= addr_r + ADDR_W'(1);
            if (x_wrap_s) begin
              x_r <= 10'd0;
              y_r <= y_r + 10'd1;
            end else begin
              x_r <= x_r + 10'd1;
            end
          end
        end
        DRAIN:   drain_cnt_r <= drain_cnt_r + CNT_W'(1);
        DONE:    drain_cnt_r <= {CNT_W{1'b0}};
        default: drain_cnt_r <= {CNT_W{1'b0}};
      endcase
    end
  end

  // Delay line: a valid entry exists only for cycles that actually issued a pixel.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      dl_valid_r <= {PIPE_LATENCY{1'b0}};
      for (int i = 0; i < PIPE_LATENCY; i++) begin
        dl_addr_r[i] <= {ADDR_W{1'b0}};
      end
    end else if (!bus.stall) begin
      dl_valid_r[0] <= (state_r == ISSUE);
      dl_addr_r[0]  <= addr_r;
      for (int i = 1; i < PIPE_LATENCY; i++) begin
        dl_valid_r[i] <= dl_valid_r[i-1];
        dl_addr_r[i]  <= dl_addr_r[i-1];
      end
    end
  end

  // Registered outputs; busy stays up through the frame_done cycle.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      issue_valid_r <= 1'b0;
      busy_r        <= 1'b0;
      frame_done_r  <= 1'b0;
      fb_we_r       <= 1'b0;
      fb_addr_r     <= {ADDR_W{1'b0}};
      fb_data_r     <= 17'd0;
    end else begin
      issue_valid_r <= (state_s == ISSUE);
      busy_r        <= (state_s != IDLE) || (state_r == DONE);
      frame_done_r  <= (state_r == DONE) && !bus.stall;
      fb_we_r       <= tail_take_s;
      if (tail_take_s) begin
        fb_addr_r <= dl_addr_r[PIPE_LATENCY-1];
        fb_data_r <= {bus.hit_in, bus.dist_in};
      end
    end
  end

  assign bus.pixel_x     = x_r;
  assign bus.pixel_y     = y_r;
  assign bus.issue_valid = issue_valid_r;
  assign bus.busy        = busy_r;
  assign bus.frame_done  = frame_done_r;
  assign bus.fb_we       = fb_we_r;
  assign bus.fb_addr     = fb_addr_r;
  assign bus.fb_data     = fb_data_r;
endmodule
